// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and defaults for the SPI engine arbiter.
// State encoding, requester ids and parameter defaults.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    XFER,
    DONE,
    HOLD,
    GAP
  } state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_POLL = 1'b1;

  localparam int CS_GAP_DEF       = 4;
  localparam int HOLD_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/spi_arb_rr.sv
// spi_arb_rr: two-way round-robin picker.
// When both request, the one not served last wins.
module spi_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic win_id
);
  import spi_arb_pkg::*;

  // pick the winner from the requests and last-served id
  always_comb begin
    win_id = REQ_CPU;
    unique case (1'b1)
      (req0 & req1):  win_id = ~last_id;
      (req1 & ~req0): win_id = REQ_POLL;
      default:        win_id = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master engine between two requesters.
// Optional macro SPI_ARB_TIMEOUT_EN: force burst release after idle HOLD.
module spi_arbiter #(
  parameter int CS_GAP       = spi_arb_pkg::CS_GAP_DEF,
  parameter int HOLD_TIMEOUT = spi_arb_pkg::HOLD_TIMEOUT_DEF
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] tx0,
  input  logic [15:0] tx1,
  input  logic        w16_0,
  input  logic        w16_1,
  input  logic        last0,
  input  logic        last1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rx_data,
  output logic        cs0_n,
  output logic        cs1_n,
  output logic        spi_start,
  output logic        spi_width_16,
  output logic [15:0] spi_data_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_data_rx,
  output logic        busy
);
  import spi_arb_pkg::*;

  state_t      state_q, state_d;
  logic        owner_q, last_srv_q;
  logic        win_id, acc_id, accept;
  logic [15:0] tx_q;
  logic        w16_q, last_q;
  logic [7:0]  rx_q, gap_q;
  logic        own_req, gap_end, cs_on;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] hold_q;
  logic        hold_end;
`endif

  spi_arb_rr u_rr (
    .req0    (req0),
    .req1    (req1),
    .last_id (last_srv_q),
    .win_id  (win_id)
  );

  assign own_req = owner_q ? req1 : req0;
  assign gap_end = (gap_q == 8'(CS_GAP - 1));
`ifdef SPI_ARB_TIMEOUT_EN
  assign hold_end = (hold_q == 16'(HOLD_TIMEOUT - 1));
`endif

  // next state and word acceptance
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    acc_id  = owner_q;
    unique case (state_q)
      IDLE: begin
        if (!spi_busy && (req0 || req1)) begin
          accept  = 1'b1;
          acc_id  = win_id;
          state_d = SETUP;
        end
      end
      SETUP: state_d = START;
      START: if (spi_busy) state_d = XFER;
      XFER:  if (!spi_busy) state_d = DONE;
      DONE:  state_d = last_q ? GAP : HOLD;
      HOLD: begin
        if (own_req) begin
          accept  = 1'b1;
          state_d = START;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (hold_end) state_d = GAP;
`endif
      end
      GAP:     if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cs_on = state_q inside {SETUP, START, XFER, DONE, HOLD};

  assign ack0         = accept & ~acc_id;
  assign ack1         = accept & acc_id;
  assign done0        = (state_q == DONE) & ~owner_q;
  assign done1        = (state_q == DONE) & owner_q;
  assign cs0_n        = ~(cs_on & ~owner_q);
  assign cs1_n        = ~(cs_on & owner_q);
  assign spi_start    = (state_q == START) & ~spi_busy;
  assign spi_width_16 = w16_q;
  assign spi_data_tx  = tx_q;
  assign rx_data      = rx_q;
  assign busy         = (state_q != IDLE);

  // state register
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // latch the accepted word and its owner
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      owner_q <= REQ_CPU;
      tx_q    <= '0;
      w16_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (accept) begin
      owner_q <= acc_id;
      tx_q    <= acc_id ? tx1 : tx0;
      w16_q   <= acc_id ? w16_1 : w16_0;
      last_q  <= acc_id ? last1 : last0;
    end
  end

  // capture the received byte as the engine goes idle
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset)
      rx_q <= '0;
    else if (state_q == XFER && !spi_busy)
      rx_q <= spi_data_rx;
  end

  // round-robin pointer follows the owner once cs is released
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset)                last_srv_q <= REQ_POLL;
    else if (state_q == GAP)  last_srv_q <= owner_q;
  end

  // cs high gap counter
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset)                gap_q <= '0;
    else if (state_q != GAP)  gap_q <= '0;
    else if (gap_end)         gap_q <= '0;
    else                      gap_q <= gap_q + 8'd1;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // idle cycles inside a burst
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset)                 hold_q <= '0;
    else if (accept)           hold_q <= '0;
    else if (state_q == HOLD)  hold_q <= hold_q + 16'd1;
  end
`endif

endmodule
